// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment capture path.
// Patterns are active-low (0 = segment lit), bit0 = a .. bit6 = g.
package seg7_pkg;

    localparam int NDIG_MAX = 8;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h18;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCEPT = 2'd2,
        LOCKED = 2'd3
    } state_t;

    // True when exactly one bit is set; callers zero-extend narrower selects.
    function automatic logic is_onehot(input logic [NDIG_MAX-1:0] x);
        return (x != '0) && ((x & (x - NDIG_MAX'(1))) == '0);
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex-to-seven-segment table.
// ok=0 (nibble=0) for any pattern outside the sixteen hex glyphs.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       ok
);

    // Table lookup; blank and every other unknown pattern are undecodable.
    always_comb begin
        nibble = 4'h0;
        ok     = 1'b1;
        case (pattern)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: ok = 1'b0;
            default:   ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Samples a multiplexed active-low 7-segment bus, filters each digit for
// STABLE_CYC identical cycles, latches the decoded nibble per digit and
// reports changes on a valid/ready event stream.
// Optional: define SEG7_ERRCNT_EN to add err_count, a saturating count of
// accepted undecodable patterns.
//
// Event handshake: evt_valid/evt_digit/evt_nibble/evt_bad are held stable
// while evt_valid=1 and evt_ready=0; a transfer happens on a rising clock
// edge with evt_valid=1 and evt_ready=1, and that same edge may load the
// next pending digit.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg,
    input  logic [NDIG-1:0]   dig_sel,
    output logic [4*NDIG-1:0] value,
    output logic [NDIG-1:0]   digit_ok,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [2:0]        evt_digit,
    output logic [3:0]        evt_nibble,
    output logic              evt_bad,
`ifdef SEG7_ERRCNT_EN
    output logic [7:0]        err_count,
`endif
    output logic [1:0]        state_dbg
);

    localparam logic [7:0] LAST = 8'(STABLE_CYC - 1);

    state_t          state, state_n;
    logic [7:0]      cnt, cnt_n;
    logic [NDIG-1:0] snap_sel;
    logic [6:0]      snap_seg;
    logic            snap_load;
    logic            wr_en;
    logic            onehot;
    logic            same;

    logic [3:0]      dec_nib;
    logic            dec_ok;

    logic [NDIG-1:0] pending;
    logic [NDIG-1:0] set_mask;
    logic [NDIG-1:0] clr_mask;
    logic            load;
    logic [2:0]      pick_idx;
    logic [3:0]      pick_nib;
    logic            pick_bad;

    assign onehot    = is_onehot(NDIG_MAX'(dig_sel));
    assign same      = (dig_sel == snap_sel) && (seg == snap_seg);
    assign state_dbg = state;

    seg7_to_hex u_dec (
        .pattern (snap_seg),
        .nibble  (dec_nib),
        .ok      (dec_ok)
    );

    // FSM state, settle counter and input snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            snap_sel <= '0;
            snap_seg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (snap_load) begin
                snap_sel <= dig_sel;
                snap_seg <= seg;
            end
        end
    end

    // Next state: any input change restarts settling (or drops to IDLE when
    // the select is no longer one-hot); ACCEPT writes for exactly one cycle.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        snap_load = 1'b0;
        wr_en     = 1'b0;
        case (state)
            SETTLE, ACCEPT, LOCKED: begin
                wr_en = (state == ACCEPT);
                if (!same) begin
                    if (onehot) begin
                        state_n   = SETTLE;
                        snap_load = 1'b1;
                        cnt_n     = 8'd1;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else if (state == SETTLE) begin
                    cnt_n = cnt + 8'd1;
                    if (cnt == LAST) state_n = ACCEPT;
                end else begin
                    state_n = LOCKED;
                end
            end
            default: begin
                if (onehot) begin
                    state_n   = SETTLE;
                    snap_load = 1'b1;
                    cnt_n     = 8'd1;
                end
            end
        endcase
    end

    // A write marks its digit pending only when the visible state changes.
    always_comb begin
        set_mask = '0;
        for (int i = 0; i < NDIG; i++) begin
            set_mask[i] = wr_en && snap_sel[i] &&
                          ((dec_ok != digit_ok[i]) ||
                           (dec_ok && (dec_nib != value[4*i +: 4])));
        end
    end

    // Latched per-digit value; an undecodable pattern keeps the old nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value    <= '0;
            digit_ok <= '0;
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (wr_en && snap_sel[i]) begin
                    digit_ok[i] <= dec_ok;
                    if (dec_ok) value[4*i +: 4] <= dec_nib;
                end
            end
        end
    end

    // Lowest pending digit and its current state form the next payload.
    always_comb begin
        pick_idx = '0;
        pick_nib = '0;
        pick_bad = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick_idx = 3'(i);
                pick_nib = digit_ok[i] ? value[4*i +: 4] : 4'h0;
                pick_bad = ~digit_ok[i];
            end
        end
    end

    assign load = (pending != '0) && (!evt_valid || evt_ready);

    // Clear only the bit being loaded; a same-cycle write re-sets it below.
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NDIG; i++) begin
            clr_mask[i] = load && (pick_idx == 3'(i));
        end
    end

    // Event output register and pending set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid  <= 1'b0;
            evt_digit  <= '0;
            evt_nibble <= '0;
            evt_bad    <= 1'b0;
            pending    <= '0;
        end else begin
            if (load) begin
                evt_valid  <= 1'b1;
                evt_digit  <= pick_idx;
                evt_nibble <= pick_nib;
                evt_bad    <= pick_bad;
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

`ifdef SEG7_ERRCNT_EN
    // Saturating count of accepted undecodable patterns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (wr_en && !dec_ok && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: decode table vectors, directed multi-cycle
// sequences and randomized traffic against a run-length reference model.
// Works with or without SEG7_ERRCNT_EN.
module tb_seg7_capture;
    import seg7_pkg::*;

    localparam int NDIG = 4;
    localparam int S    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [6:0]        seg = '0;
    logic [NDIG-1:0]   dig_sel = '0;
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   digit_ok;
    logic              evt_valid;
    logic              evt_ready = 1'b0;
    logic [2:0]        evt_digit;
    logic [3:0]        evt_nibble;
    logic              evt_bad;
    logic [1:0]        state_dbg;
`ifdef SEG7_ERRCNT_EN
    logic [7:0]        err_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    seg7_capture #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .value      (value),
        .digit_ok   (digit_ok),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_digit  (evt_digit),
        .evt_nibble (evt_nibble),
        .evt_bad    (evt_bad),
`ifdef SEG7_ERRCNT_EN
        .err_count  (err_count),
`endif
        .state_dbg  (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Active-low glyphs for 0..F, independent copy of the display table.
    logic [6:0] hex_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: per-digit state, pending set, event slot, run length.
    logic [3:0]        m_val [NDIG];
    logic [NDIG-1:0]   m_ok, m_pend;
    logic              m_ev_valid, m_ev_bad;
    logic [2:0]        m_ev_dig;
    logic [3:0]        m_ev_nib;
    int                m_run, m_err;
    logic [NDIG+6:0]   m_prev;
    logic              m_prev_oh, m_acc;
    int                m_acc_dig;
    logic [6:0]        m_acc_pat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int sel_idx(input logic [NDIG-1:0] s);
        int r = 0;
        for (int i = 0; i < NDIG; i++) if (s[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NDIG; i++) m_val[i] = '0;
        m_ok = '0; m_pend = '0;
        m_ev_valid = 0; m_ev_bad = 0; m_ev_dig = '0; m_ev_nib = '0;
        m_run = 0; m_err = 0; m_prev = '0; m_prev_oh = 0;
        m_acc = 0; m_acc_dig = 0; m_acc_pat = '0;
    endtask

    // One clock edge of the model, from the inputs present at that edge.
    task automatic model_step();
        logic found, ok, oh;
        logic [3:0] nib;
        // event slot sees the digit state as it was before this edge
        if (m_ev_valid && evt_ready) m_ev_valid = 0;
        if (!m_ev_valid) begin
            found = 0;
            for (int i = 0; i < NDIG; i++) begin
                if (!found && m_pend[i]) begin
                    found = 1;
                    m_ev_valid = 1;
                    m_ev_dig = 3'(i);
                    m_ev_nib = m_ok[i] ? m_val[i] : 4'h0;
                    m_ev_bad = !m_ok[i];
                    m_pend[i] = 0;
                end
            end
        end
        // write decided one sample earlier
        if (m_acc) begin
            ok = 0; nib = 0;
            for (int k = 0; k < 16; k++) if (hex_pat[k] == m_acc_pat) begin ok = 1; nib = 4'(k); end
            if ((ok != m_ok[m_acc_dig]) || (ok && nib != m_val[m_acc_dig])) m_pend[m_acc_dig] = 1;
            if (ok) m_val[m_acc_dig] = nib;
            m_ok[m_acc_dig] = ok;
            if (!ok && m_err < 255) m_err++;
        end
        // run of identical one-hot samples; acceptance exactly at length S
        oh = ($countones(dig_sel) == 1);
        if (oh) m_run = (m_prev_oh && m_prev == {dig_sel, seg}) ? m_run + 1 : 1;
        else    m_run = 0;
        m_prev    = {dig_sel, seg};
        m_prev_oh = oh;
        m_acc     = (m_run == S);
        m_acc_dig = sel_idx(dig_sel);
        m_acc_pat = seg;
    endtask

    task automatic check_all();
        logic [31:0] expv = '0;
        for (int i = 0; i < NDIG; i++) expv[4*i +: 4] = m_val[i];
        chk("value", 32'(value), expv);
        chk("digit_ok", 32'(digit_ok), 32'(m_ok));
        chk("evt_valid", 32'(evt_valid), 32'(m_ev_valid));
        if (m_ev_valid) chk("evt_payload", {24'd0, evt_digit, evt_nibble, evt_bad},
                            {24'd0, m_ev_dig, m_ev_nib, m_ev_bad});
`ifdef SEG7_ERRCNT_EN
        chk("err_count", 32'(err_count), 32'(m_err));
`endif
    endtask

    // Driver tasks
    task automatic drive(input logic [NDIG-1:0] s, input logic [6:0] g, input logic r);
        dig_sel = s; seg = g; evt_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 0;
        drive('0, 7'h7F, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
    endtask

    typedef struct {
        logic [NDIG-1:0] sel;
        logic [6:0]      pat;
        logic [3:0]      exp_nib;
        logic            exp_ok;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int d, nev, n_d2, d2_nib, first_dig, r;

        tbl[0]  = '{4'b0001, 7'h40, 4'h0, 1'b1};
        tbl[1]  = '{4'b0010, 7'h79, 4'h1, 1'b1};
        tbl[2]  = '{4'b0100, 7'h24, 4'h2, 1'b1};
        tbl[3]  = '{4'b1000, 7'h30, 4'h3, 1'b1};
        tbl[4]  = '{4'b0001, 7'h19, 4'h4, 1'b1};
        tbl[5]  = '{4'b0010, 7'h12, 4'h5, 1'b1};
        tbl[6]  = '{4'b0100, 7'h02, 4'h6, 1'b1};
        tbl[7]  = '{4'b1000, 7'h78, 4'h7, 1'b1};
        tbl[8]  = '{4'b0001, 7'h00, 4'h8, 1'b1};
        tbl[9]  = '{4'b0010, 7'h18, 4'h9, 1'b1};
        tbl[10] = '{4'b0100, 7'h08, 4'hA, 1'b1};
        tbl[11] = '{4'b1000, 7'h03, 4'hB, 1'b1};
        tbl[12] = '{4'b0001, 7'h46, 4'hC, 1'b1};
        tbl[13] = '{4'b0010, 7'h21, 4'hD, 1'b1};
        tbl[14] = '{4'b0100, 7'h06, 4'hE, 1'b1};
        tbl[15] = '{4'b1000, 7'h0E, 4'hF, 1'b1};
        tbl[16] = '{4'b0001, 7'h7F, 4'hC, 1'b0};
        tbl[17] = '{4'b0010, 7'h01, 4'hD, 1'b0};

        // Reset state
        do_reset();
        #1;
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_ok", 32'(digit_ok), 32'h0);
        chk("rst_evt", {23'd0, evt_valid, evt_digit, evt_nibble, evt_bad}, 32'h0);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));

        // Basic accept of 3 on digit 0, event held until ready
        drive(4'b0001, 7'h30, 0);
        repeat (S) tick();
        chk("t1_ok_before", 32'(digit_ok[0]), 32'h0);
        tick();
        chk("t1_value", 32'(value[3:0]), 32'h3);
        chk("t1_ok", 32'(digit_ok[0]), 32'h1);
        chk("t1_evt_early", 32'(evt_valid), 32'h0);
        tick();
        chk("t1_evt_valid", 32'(evt_valid), 32'h1);
        repeat (4) begin
            tick();
            chk("t1_hold", {23'd0, evt_valid, evt_digit, evt_nibble, evt_bad},
                {23'd0, 1'b1, 3'd0, 4'd3, 1'b0});
        end
        evt_ready = 1;
        tick();
        chk("t1_done", 32'(evt_valid), 32'h0);

        // Glitch restarts the filter: 3 never accepted on digit 3, 8 is
        drive(4'b0000, 7'h30, 1);
        tick();
        drive(4'b1000, 7'h30, 1);
        repeat (7) begin tick(); chk("t2_no3", 32'(digit_ok[3]), 32'h0); end
        drive(4'b1000, 7'h00, 1);
        repeat (8) begin tick(); chk("t2_wait", 32'(digit_ok[3]), 32'h0); end
        tick();
        chk("t2_value", 32'(value[15:12]), 32'h8);
        chk("t2_ok", 32'(digit_ok[3]), 32'h1);

        // Blank on a digit that held 5: ok drops, nibble kept, bad event
        drive(4'b0010, 7'h12, 1);
        repeat (S + 3) tick();
        chk("t3_pre", 32'(value[7:4]), 32'h5);
        drive(4'b0010, 7'h7F, 0);
        repeat (S + 1) tick();
        chk("t3_ok", 32'(digit_ok[1]), 32'h0);
        chk("t3_value", 32'(value[7:4]), 32'h5);
        for (int k = 0; k < 4 && !evt_valid; k++) tick();
        chk("t3_evt", {23'd0, evt_valid, evt_digit, evt_nibble, evt_bad},
            {23'd0, 1'b1, 3'd1, 4'd0, 1'b1});
`ifdef SEG7_ERRCNT_EN
        chk("t3_errcnt", 32'(err_count), 32'h1);
`endif
        evt_ready = 1;
        tick();

        // Multi-hot select: stays IDLE, nothing written, no events
        drive(4'b0011, 7'h30, 1);
        repeat (20) begin
            tick();
            chk("t4_state", 32'(state_dbg), 32'(IDLE));
            chk("t4_value", 32'(value), 32'h8053);
            chk("t4_ok", 32'(digit_ok), 32'b1001);
            chk("t4_evt", 32'(evt_valid), 32'h0);
        end

        // Coalescing: slot busy with digit 3, digit 2 goes 4 -> 5 -> 6
        drive(4'b1000, 7'h79, 0);
        repeat (S + 2) tick();
        chk("t5_slot", {23'd0, evt_valid, evt_digit, evt_nibble, evt_bad},
            {23'd0, 1'b1, 3'd3, 4'd1, 1'b0});
        drive(4'b0100, 7'h19, 0); repeat (S + 1) tick();
        drive(4'b0100, 7'h12, 0); repeat (S + 1) tick();
        drive(4'b0100, 7'h02, 0); repeat (S + 1) tick();
        chk("t5_value", 32'(value[11:8]), 32'h6);
        evt_ready = 1;
        nev = 0; n_d2 = 0; d2_nib = -1; first_dig = -1;
        repeat (8) begin
            if (evt_valid) begin
                if (nev == 0) first_dig = int'(evt_digit);
                nev++;
                if (evt_digit == 3'd2) begin n_d2++; d2_nib = int'(evt_nibble); end
            end
            tick();
        end
        chk("t5_nev", 32'(nev), 32'd2);
        chk("t5_first", 32'(first_dig), 32'd3);
        chk("t5_n_d2", 32'(n_d2), 32'd1);
        chk("t5_d2_nib", 32'(d2_nib), 32'd6);

        // Async reset mid-SETTLE with an event outstanding
        drive(4'b0001, 7'h40, 0);
        repeat (S + 2) tick();
        drive(4'b0010, 7'h24, 0);
        repeat (3) tick();
        chk("t6_settle", 32'(state_dbg), 32'(SETTLE));
        chk("t6_evt_pre", 32'(evt_valid), 32'h1);
        #2 rst_n = 0;
        #1;
        chk("t6_value", 32'(value), 32'h0);
        chk("t6_ok", 32'(digit_ok), 32'h0);
        chk("t6_evt", {23'd0, evt_valid, evt_digit, evt_nibble, evt_bad}, 32'h0);
        chk("t6_state", 32'(state_dbg), 32'(IDLE));
        model_reset();
        drive('0, 7'h7F, 0);
        @(posedge clk);
        #3 rst_n = 1;
        drive(4'b0001, 7'h24, 1);
        repeat (S + 1) tick();
        chk("t6_restart_val", 32'(value), 32'h0002);
        chk("t6_restart_ok", 32'(digit_ok), 32'b0001);

        // Table-driven decode vectors
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].sel, tbl[i].pat, 1);
            repeat (S + 1) tick();
            d = sel_idx(tbl[i].sel);
            chk("tbl_nib", 32'(value[4*d +: 4]), 32'(tbl[i].exp_nib));
            chk("tbl_ok", 32'(digit_ok[d]), 32'(tbl[i].exp_ok));
        end

        // Randomized traffic against the model
        do_reset();
        repeat (150) begin
            r = $urandom_range(0, 9);
            if (r == 0)      dig_sel = '0;
            else if (r == 1) dig_sel = NDIG'($urandom_range(0, 15));
            else             dig_sel = NDIG'(1) << $urandom_range(0, NDIG - 1);
            r = $urandom_range(0, 9);
            if (r == 0)      seg = 7'h7F;
            else if (r == 1) seg = 7'($urandom_range(0, 127));
            else             seg = hex_pat[$urandom_range(0, 15)];
            repeat ($urandom_range(1, 12)) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        drive('0, 7'h7F, 1);
        repeat (12) tick();
        chk("drain", 32'(evt_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Reader/inverse side of the team's hex-to-seven-segment path: samples a time-multiplexed, active-low 7-segment bus and recovers the 4-bit hex value shown on each digit.
- Per-digit settle filter, latched value register, and a valid/ready change-event stream toward the processor's I/O bus.
- Used for loopback self-test of display drivers and for snooping external panels.

Parameters:
- NDIG, 4, number of multiplexed digits (1..8).
- STABLE_CYC, 8, consecutive identical cycles required to accept a pattern (2..255).

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous active-low reset.
- seg  in  7  active-low segments, bit0=a..bit6=g (0 = lit).
- dig_sel  in  NDIG  active-high digit enable, expected one-hot.
- value  out  4*NDIG  accepted nibbles, digit i at [4i+3:4i].
- digit_ok  out  NDIG  digit i holds a valid decoded nibble.
- evt_valid  out  1  change event available.
- evt_ready  in  1  consumer accepts event.
- evt_digit  out  3  digit index of event.
- evt_nibble  out  4  new nibble.
- evt_bad  out  1  event reports an undecodable pattern (evt_nibble=0).

Behaviour:
- Reset: value=0, digit_ok=0, evt_valid=0, evt_digit=0, evt_nibble=0, evt_bad=0, pending=0, FSM=IDLE, counter=0.
- Decode table, active-low hex, 0..F: 40 79 24 30 19 12 02 78 00 18 08 03 46 21 06 0E. Any other pattern is bad.
- FSM states:
  - IDLE: dig_sel not one-hot (zero or multiple bits). Stay here.
  - SETTLE: one-hot dig_sel seen. Snapshot {dig_sel, seg}, counter=1. Each cycle with identical inputs increments the counter. Any change restarts SETTLE with a new snapshot, or goes to IDLE if no longer one-hot. Reaching STABLE_CYC goes to ACCEPT.
  - ACCEPT (1 cycle): decode the snapshot and write digit i. If the nibble or ok status changed, set pending[i]. Go to LOCKED.
  - LOCKED: hold while inputs are unchanged. Any change acts as in SETTLE.
- Acceptance latency: the last required stable cycle is N. value and digit_ok update at edge N+1. evt_valid rises at N+2 at the earliest.
- Bad pattern: digit_ok[i]=0, value nibble unchanged.
- Event stream:
  - When evt_valid=0 and pending is nonzero, load the lowest pending index and clear its bit.
  - Payload is held stable while evt_valid && !evt_ready.
  - The transfer cycle may reload the next pending entry back-to-back.
  - Repeated changes to a pending digit coalesce. The emitted payload is the digit's state at load time.
  - A write to digit i in the same cycle its pending bit is cleared by a load leaves pending[i]=1.
- Reset mid-operation clears everything immediately, including an unaccepted event.

Optional Feature:
- SEG7_ERRCNT_EN defined: adds output err_count (8 bits), reset 0. It increments once per ACCEPT of a bad pattern and saturates at 255.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package seg7_pkg:
  - the 16 active-low pattern constants;
  - SEG_BLANK=7'h7F;
  - FSM state enum (IDLE, SETTLE, ACCEPT, LOCKED);
  - NDIG_MAX=8.
- Sub-module seg7_to_hex (combinational): input 7-bit pattern; outputs nibble and ok. Instantiated once on the snapshot.

Test Plan:
- Reset then dig_sel=0001, seg=7'h30 for 8 cycles -> value[3:0]=3 and digit_ok[0]=1 one cycle later. Event {digit 0, nibble 3, bad 0} is held until evt_ready.
- seg=7'h30 for 7 cycles, glitch to 7'h00 for 1 cycle, then 7'h00 for 8 cycles -> no accept of 3; accept 8 only.
- dig_sel=0010, seg=7'h7F (blank) for 8 cycles -> digit_ok[1]=0, value[7:4] unchanged, event bad=1. With SEG7_ERRCNT_EN, err_count=1.
- dig_sel=0011 for 20 cycles -> FSM stays IDLE, no writes, no events.
- evt_ready=0 while digit 2 cycles through 7'h19, 7'h12, 7'h02, then evt_ready=1 -> exactly one digit-2 event with nibble 6.
- Assert Resetn=0 mid-SETTLE with evt_valid=1 -> all outputs 0 asynchronously. After release, capture restarts from IDLE.
